// File: rtl/spike_index_decoder_pkg.sv
// Shared types for the spike index decoder slice.
// Holds the decoder FSM state encoding used by the top-level control.
// No logic lives here; purely declarations.
package spike_index_decoder_pkg;

   // Decoder control states:
   //   ST_ACCUM - indices are accepted and OR'd into the current timestep
   //   ST_STALL - a timestep closed while the holding register was still
   //              occupied; intake is frozen until downstream drains it
   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_STALL = 1'b1
   } state_t;

endpackage : spike_index_decoder_pkg

// File: rtl/spike_index_decoder_onehot_decoder.sv
// Binary spike index to one-hot vector; inverse of the priority encoder for single-hot inputs.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates the enable with its own handshake.
module onehot_decoder #(
   parameter int IN_DSIZE  = 4,
   parameter int OUT_DSIZE = 16
) (
   input  logic [IN_DSIZE-1:0]  idx_i,
   input  logic                 en_i,
   output logic [OUT_DSIZE-1:0] onehot_o,
   output logic                 out_of_range_o
);

   // Decode the index; indices past the bitmap width produce no bit and
   // raise out_of_range_o instead, so the caller can flag them.
   always_comb begin
      int unsigned idx_u;
      idx_u          = 32'(idx_i);
      onehot_o       = '0;
      out_of_range_o = en_i && (idx_u >= 32'(OUT_DSIZE));
      for (int i = 0; i < OUT_DSIZE; i++) begin
         if (en_i && (idx_u == 32'(i))) begin
            onehot_o[i] = 1'b1;
         end
      end
   end

endmodule : onehot_decoder

// File: rtl/spike_index_decoder.sv
// Decodes a stream of spike indices into a per-timestep bitmap plus count and publishes it on step_i.
// Latency: index visible in accum one cycle after accept; step_i gives map_valid_o one cycle later.
// Backpressure: step while the holding register is blocked enters STALL, dropping idx_ready_o until drained.
module spike_index_decoder
   import spike_index_decoder_pkg::*;
#(
   parameter int IN_DSIZE  = 4,
   parameter int OUT_DSIZE = 16,
   parameter int CNT_W     = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 idx_valid_i,
   input  logic [IN_DSIZE-1:0]  idx_data_i,
   output logic                 idx_ready_o,
   input  logic                 step_i,
   output logic                 map_valid_o,
   output logic [OUT_DSIZE-1:0] map_data_o,
   output logic [CNT_W-1:0]     map_cnt_o,
   input  logic                 map_ready_i,
   output logic                 err_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t                 state_q, state_d;
   logic [OUT_DSIZE-1:0]   accum_q, accum_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   map_valid_q, map_valid_d;
   logic [OUT_DSIZE-1:0]   map_data_q, map_data_d;
   logic [CNT_W-1:0]       map_cnt_q, map_cnt_d;
   logic                   err_q, err_d;

   logic                   accept;
   logic [OUT_DSIZE-1:0]   dec_onehot;
   logic                   dec_oor;
   logic                   cnt_inc;
   logic [OUT_DSIZE-1:0]   accum_merged;
   logic [CNT_W-1:0]       cnt_merged;
   logic                   handshake;
   logic                   hold_free;

   // Intake is open only while accumulating; STALL freezes the timestep.
   assign idx_ready_o = (state_q == ST_ACCUM);
   assign accept      = idx_valid_i & idx_ready_o;

   onehot_decoder #(
      .IN_DSIZE  (IN_DSIZE),
      .OUT_DSIZE (OUT_DSIZE)
   ) u_dec (
      .idx_i          (idx_data_i),
      .en_i           (accept),
      .onehot_o       (dec_onehot),
      .out_of_range_o (dec_oor)
   );

   // Out-of-range indices are consumed but never counted.
   assign cnt_inc      = accept & ~dec_oor;

   // Accum/count including whatever index is accepted this cycle, so a
   // same-cycle index can be folded into a closing timestep.
   assign accum_merged = accum_q | dec_onehot;
   assign cnt_merged   = (cnt_inc && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_W'(1)) : cnt_q;

   // Holding register can take a new bitmap if empty or draining this edge.
   assign handshake    = map_valid_q & map_ready_i;
   assign hold_free    = ~map_valid_q | map_ready_i;

   // Next-state, accumulation and holding-register control.
   always_comb begin
      state_d     = state_q;
      accum_d     = accum_q;
      cnt_d       = cnt_q;
      map_valid_d = map_valid_q;
      map_data_d  = map_data_q;
      map_cnt_d   = map_cnt_q;
      err_d       = err_q | (accept & dec_oor);

      case (state_q)
         ST_ACCUM: begin
            if (step_i && hold_free) begin
               // Close the timestep straight into the holding register.
               map_data_d  = accum_merged;
               map_cnt_d   = cnt_merged;
               map_valid_d = 1'b1;
               accum_d     = '0;
               cnt_d       = '0;
            end else if (step_i) begin
               // Downstream still owns the previous bitmap; park this one
               // in accum (with any same-cycle index) until it drains.
               accum_d = accum_merged;
               cnt_d   = cnt_merged;
               state_d = ST_STALL;
            end else begin
               accum_d = accum_merged;
               cnt_d   = cnt_merged;
               if (handshake) begin
                  map_valid_d = 1'b0;
               end
            end
         end

         ST_STALL: begin
            // A further tick now has nowhere to go; flag it and ignore it.
            if (step_i) begin
               err_d = 1'b1;
            end
            if (handshake) begin
               // Back-to-back publish: valid stays high with the parked map.
               map_data_d  = accum_q;
               map_cnt_d   = cnt_q;
               map_valid_d = 1'b1;
               accum_d     = '0;
               cnt_d       = '0;
               state_d     = ST_ACCUM;
            end
         end

         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   // State and datapath registers; reset discards all timestep content.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_ACCUM;
         accum_q     <= '0;
         cnt_q       <= '0;
         map_valid_q <= 1'b0;
         map_data_q  <= '0;
         map_cnt_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         accum_q     <= accum_d;
         cnt_q       <= cnt_d;
         map_valid_q <= map_valid_d;
         map_data_q  <= map_data_d;
         map_cnt_q   <= map_cnt_d;
         err_q       <= err_d;
      end
   end

   assign map_valid_o = map_valid_q;
   assign map_data_o  = map_data_q;
   assign map_cnt_o   = map_cnt_q;
   assign err_o       = err_q;

endmodule : spike_index_decoder

// File: tb/tb_spike_index_decoder.sv
// Directed bench for spike_index_decoder with a queue-based scoreboard.
// Two instances: default geometry, and a 12-wide bitmap with a 4-bit counter.
// Stimulus pushes expected bitmaps; monitors pop them on each output handshake.
module tb_spike_index_decoder;

   logic clk;
   logic rst;

   // Instance A: IN_DSIZE=4, OUT_DSIZE=16, CNT_W=8
   logic        a_idx_valid;
   logic [3:0]  a_idx_data;
   logic        a_idx_ready;
   logic        a_step;
   logic        a_map_valid;
   logic [15:0] a_map_data;
   logic [7:0]  a_map_cnt;
   logic        a_map_ready;
   logic        a_err;

   // Instance B: IN_DSIZE=4, OUT_DSIZE=12, CNT_W=4
   logic        b_idx_valid;
   logic [3:0]  b_idx_data;
   logic        b_idx_ready;
   logic        b_step;
   logic        b_map_valid;
   logic [11:0] b_map_data;
   logic [3:0]  b_map_cnt;
   logic        b_map_ready;
   logic        b_err;

   typedef struct {
      logic [15:0] data;
      logic [7:0]  cnt;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int n_checks = 0;
   int n_fail   = 0;

   spike_index_decoder #(.IN_DSIZE(4), .OUT_DSIZE(16), .CNT_W(8)) dut_a (
      .clk_i       (clk),
      .rst_i       (rst),
      .idx_valid_i (a_idx_valid),
      .idx_data_i  (a_idx_data),
      .idx_ready_o (a_idx_ready),
      .step_i      (a_step),
      .map_valid_o (a_map_valid),
      .map_data_o  (a_map_data),
      .map_cnt_o   (a_map_cnt),
      .map_ready_i (a_map_ready),
      .err_o       (a_err)
   );

   spike_index_decoder #(.IN_DSIZE(4), .OUT_DSIZE(12), .CNT_W(4)) dut_b (
      .clk_i       (clk),
      .rst_i       (rst),
      .idx_valid_i (b_idx_valid),
      .idx_data_i  (b_idx_data),
      .idx_ready_o (b_idx_ready),
      .step_i      (b_step),
      .map_valid_o (b_map_valid),
      .map_data_o  (b_map_data),
      .map_cnt_o   (b_map_cnt),
      .map_ready_i (b_map_ready),
      .err_o       (b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus on instance A; inputs return idle afterwards.
   task automatic drive_a(input logic v, input logic [3:0] d, input logic s);
      a_idx_valid = v;
      a_idx_data  = d;
      a_step      = s;
      @(posedge clk);
      #1;
      a_idx_valid = 1'b0;
      a_step      = 1'b0;
   endtask

   task automatic drive_b(input logic v, input logic [3:0] d, input logic s);
      b_idx_valid = v;
      b_idx_data  = d;
      b_step      = s;
      @(posedge clk);
      #1;
      b_idx_valid = 1'b0;
      b_step      = 1'b0;
   endtask

   task automatic push_a(input logic [15:0] d, input logic [7:0] c);
      exp_t e;
      e.data = d;
      e.cnt  = c;
      q_a.push_back(e);
   endtask

   task automatic push_b(input logic [15:0] d, input logic [7:0] c);
      exp_t e;
      e.data = d;
      e.cnt  = c;
      q_b.push_back(e);
   endtask

   // Monitor A: every published bitmap taken by downstream must match the
   // oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && a_map_valid && a_map_ready) begin
         if (q_a.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_unexpected_map: got data 0x%0h cnt %0d, expected no output", a_map_data, a_map_cnt);
         end else begin
            exp_t e;
            e = q_a.pop_front();
            check("a_map_data", 32'(a_map_data), 32'(e.data));
            check("a_map_cnt", 32'(a_map_cnt), 32'(e.cnt));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b_map_valid && b_map_ready) begin
         if (q_b.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_unexpected_map: got data 0x%0h cnt %0d, expected no output", b_map_data, b_map_cnt);
         end else begin
            exp_t e;
            e = q_b.pop_front();
            check("b_map_data", 32'(b_map_data), 32'(e.data[11:0]));
            check("b_map_cnt", 32'(b_map_cnt), 32'(e.cnt[3:0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      a_idx_valid = 1'b0; a_idx_data = '0; a_step = 1'b0; a_map_ready = 1'b0;
      b_idx_valid = 1'b0; b_idx_data = '0; b_step = 1'b0; b_map_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("a_rst_valid", 32'(a_map_valid), 0);
      check("a_rst_data",  32'(a_map_data), 0);
      check("a_rst_cnt",   32'(a_map_cnt), 0);
      check("a_rst_err",   32'(a_err), 0);
      check("b_rst_valid", 32'(b_map_valid), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Mid-stream reset: a held bitmap and a pending index are discarded.
      drive_a(1'b1, 4'd5, 1'b0);
      drive_a(1'b0, 4'd0, 1'b1);
      check("a_pre_rst_valid", 32'(a_map_valid), 1);
      drive_a(1'b1, 4'd6, 1'b0);
      rst = 1'b1;
      #1;
      check("a_rst_mid_valid", 32'(a_map_valid), 0);
      check("a_rst_mid_data",  32'(a_map_data), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      a_map_ready = 1'b1;
      check("a_post_rst_ready", 32'(a_idx_ready), 1);
      repeat (3) drive_a(1'b0, 4'd0, 1'b0);
      check("a_post_rst_no_valid", 32'(a_map_valid), 0);
      check("a_post_rst_cnt",      32'(a_map_cnt), 0);

      // Basic decode with duplicate index.
      push_a(16'h0088, 8'd3);
      drive_a(1'b1, 4'd3, 1'b0);
      drive_a(1'b1, 4'd7, 1'b0);
      drive_a(1'b1, 4'd3, 1'b0);
      drive_a(1'b0, 4'd0, 1'b1);
      check("a_basic_valid_up", 32'(a_map_valid), 1);
      drive_a(1'b0, 4'd0, 1'b0);
      check("a_basic_valid_down", 32'(a_map_valid), 0);

      // Same-cycle merge, then an empty timestep.
      push_a(16'h8000, 8'd1);
      drive_a(1'b1, 4'd15, 1'b1);
      push_a(16'h0000, 8'd0);
      drive_a(1'b0, 4'd0, 1'b1);
      drive_a(1'b0, 4'd0, 1'b0);
      check("a_merge_idle", 32'(a_map_valid), 0);

      // Back-pressure into STALL, overrun tick, then release.
      a_map_ready = 1'b0;
      push_a(16'h0002, 8'd1);
      drive_a(1'b1, 4'd1, 1'b1);
      push_a(16'h0004, 8'd1);
      drive_a(1'b1, 4'd2, 1'b0);
      drive_a(1'b0, 4'd0, 1'b1);
      check("a_stall_ready", 32'(a_idx_ready), 0);
      check("a_stall_data",  32'(a_map_data), 32'h0002);
      check("a_stall_err0",  32'(a_err), 0);
      drive_a(1'b1, 4'd9, 1'b0);
      check("a_stall_ready2", 32'(a_idx_ready), 0);
      drive_a(1'b0, 4'd0, 1'b1);
      check("a_overrun_err",  32'(a_err), 1);
      check("a_overrun_data", 32'(a_map_data), 32'h0002);
      a_map_ready = 1'b1;
      drive_a(1'b0, 4'd0, 1'b0);
      check("a_release_data",  32'(a_map_data), 32'h0004);
      check("a_release_valid", 32'(a_map_valid), 1);
      check("a_release_ready", 32'(a_idx_ready), 1);
      drive_a(1'b0, 4'd0, 1'b0);
      check("a_release_drained", 32'(a_map_valid), 0);
      repeat (2) drive_a(1'b0, 4'd0, 1'b0);

      // Instance B: out-of-range indices, width boundary, saturation.
      b_map_ready = 1'b1;
      check("b_err_clean", 32'(b_err), 0);
      drive_b(1'b1, 4'd13, 1'b0);
      check("b_oor_err", 32'(b_err), 1);
      drive_b(1'b1, 4'd12, 1'b0);
      drive_b(1'b1, 4'd11, 1'b0);
      drive_b(1'b1, 4'd4, 1'b0);
      push_b(16'h0810, 8'd2);
      drive_b(1'b0, 4'd0, 1'b1);
      drive_b(1'b0, 4'd0, 1'b0);

      push_b(16'h0001, 8'd15);
      for (int i = 0; i < 20; i++) drive_b(1'b1, 4'd0, 1'b0);
      drive_b(1'b0, 4'd0, 1'b1);
      repeat (2) drive_b(1'b0, 4'd0, 1'b0);
      check("b_err_sticky", 32'(b_err), 1);

      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_spike_index_decoder
